sd_bmp_stream: RTL

- Parametrised successor to the single-format BMP loader. Reads an uncompressed BMP file from SD card, starting at a given LBA, through the sector-read interface of the SD card controller.
- Parses and validates the BMP header, then streams pixels to the frame writer. It strips row padding and repacks BGR(A) bytes into a selectable output pixel format.
- Supports 24- and 32-bpp sources, optional height check, per-line markers and error reporting.

---
 rtl/sd_bmp_stream.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_bmp_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sd_bmp_stream
//  Description : Loads an uncompressed 24/32-bpp BMP file from SD card
//                sectors, validates its header, strips row padding and
//                streams repacked pixels to a frame writer.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_bmp_stream #(
   parameter int OUT_FMT = 0,
   parameter int OUT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      start_lba,
   input  logic [15:0]      exp_width,
   input  logic [15:0]      exp_height,
   output logic             busy,
   output logic             done,
   output logic [2:0]       err,
   output logic [3:0]       state_code,
   output logic             write_req,
   input  logic             write_req_ack,
   output logic             write_en,
   output logic [OUT_W-1:0] write_data,
   output logic             line_end,
   input  logic             sd_init_done,
   output logic             sd_sec_read,
   output logic [31:0]      sd_sec_read_addr,
   input  logic [7:0]       sd_sec_read_data,
   input  logic             sd_sec_read_data_valid,
   input  logic             sd_sec_read_end
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_HDR_RD   = 4'd1,
      S_HDR_CHK  = 4'd2,
      S_REQ      = 4'd3,
      S_DAT_RD   = 4'd4,
      S_NEXT_SEC = 4'd5,
      S_DONE     = 4'd6,
      S_ERR      = 4'd7
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  err_q, err_d;
   logic [31:0] start_lba_q, sec_addr_q, offset_q, width_q, height_q;
   logic [15:0] exp_w_q, exp_h_q, bpp_q;
   logic [7:0]  sig0_q, sig1_q, b_q, g_q, r_q;
   logic [8:0]  idx_q;
   logic        first_sec_q, rd_q;
   logic [17:0] rowbyte_q;
   logic [15:0] col_q, row_q;
   logic [1:0]  pb_q;
   logic        wen_q, lend_q;
   logic [OUT_W-1:0] wdata_q;

   // Datapath helpers: row geometry, byte classification, pixel emission
   logic        w_start_ok, w_bp4, w_rows_done, w_skip, w_take, w_pix_byte;
   logic        w_last_pb, w_emit, w_row_last, w_col_last, w_done_next, w_launch;
   logic [17:0] w_rowbytes, w_stride;
   logic [15:0] w_row_d;
   logic [7:0]  w_r;
   logic [31:0] w_pix;

   assign w_start_ok  = start && sd_init_done &&
                        (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
   assign w_bp4       = (bpp_q == 16'd32);
   assign w_rowbytes  = w_bp4 ? {width_q[15:0], 2'b00}
                              : ({2'b00, width_q[15:0]} + {1'b0, width_q[15:0], 1'b0});
   assign w_stride    = (w_rowbytes + 18'd3) & ~18'd3;
   assign w_rows_done = (row_q == height_q[15:0]);
   assign w_skip      = first_sec_q && (idx_q < offset_q[8:0]);
   assign w_take      = (state_q == S_DAT_RD) && sd_sec_read_data_valid && !w_skip && !w_rows_done;
   assign w_pix_byte  = w_take && (rowbyte_q < w_rowbytes);
   assign w_last_pb   = (pb_q == (w_bp4 ? 2'd3 : 2'd2));
   assign w_emit      = w_pix_byte && w_last_pb;
   assign w_row_last  = w_pix_byte && (rowbyte_q == w_rowbytes - 18'd1);
   assign w_col_last  = (col_q == width_q[15:0] - 16'd1);
   assign w_row_d     = row_q + {15'd0, w_row_last};
   assign w_done_next = (w_row_d == height_q[15:0]);
   assign w_launch    = (state_d == S_HDR_RD && state_q != S_HDR_RD) ||
                        (state_d == S_DAT_RD && state_q != S_DAT_RD);

   // Pixel repacking; in 24 bpp the R byte arrives on the emitting cycle
   always_comb begin
      w_r = (pb_q == 2'd2) ? sd_sec_read_data : r_q;
      case (OUT_FMT)
         1:       w_pix = {8'h00, w_r, g_q, b_q};
         2:       w_pix = {16'h0000, w_r[7:3], g_q[7:2], b_q[7:3]};
         default: w_pix = {w_r, g_q, b_q, 8'h00};
      endcase
   end

   // State and error-code register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         err_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Next-state, header validation and status outputs
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      busy       = 1'b0;
      done       = 1'b0;
      write_req  = 1'b0;
      state_code = 4'd1;
      case (state_q)
         S_IDLE: begin
            state_code = sd_init_done ? 4'd1 : 4'd0;
            if (w_start_ok) begin
               state_d = S_HDR_RD;
               err_d   = 3'd0;
            end
         end
         S_HDR_RD: begin
            busy       = 1'b1;
            state_code = 4'd2;
            if (sd_sec_read_end) state_d = S_HDR_CHK;
         end
         S_HDR_CHK: begin
            busy       = 1'b1;
            state_code = 4'd2;
            state_d    = S_REQ;
            if (sig0_q != 8'h42 || sig1_q != 8'h4D) begin
               err_d = 3'd1; state_d = S_ERR;
            end else if (bpp_q != 16'd24 && bpp_q != 16'd32) begin
               err_d = 3'd2; state_d = S_ERR;
            end else if (width_q != {16'd0, exp_w_q} || width_q == 32'd0) begin
               err_d = 3'd3; state_d = S_ERR;
            end else if (exp_h_q != 16'd0 && height_q != {16'd0, exp_h_q}) begin
               err_d = 3'd4; state_d = S_ERR;
            end else if (offset_q < 32'd54) begin
               err_d = 3'd5; state_d = S_ERR;
            end else if (height_q[31]) begin
               err_d = 3'd6; state_d = S_ERR;
            end
         end
         S_REQ: begin
            busy       = 1'b1;
            state_code = 4'd3;
            write_req  = 1'b1;
            if (write_req_ack) state_d = S_DAT_RD;
         end
         S_DAT_RD: begin
            busy       = 1'b1;
            state_code = 4'd3;
            if (sd_sec_read_end) state_d = w_done_next ? S_DONE : S_NEXT_SEC;
         end
         S_NEXT_SEC: begin
            busy       = 1'b1;
            state_code = 4'd3;
            state_d    = S_DAT_RD;
         end
         S_DONE, S_ERR: begin
            done       = (state_q == S_DONE);
            state_code = (state_q == S_DONE) ? 4'd4 : 4'd5;
            state_d    = S_IDLE;
            if (w_start_ok) begin
               state_d = S_HDR_RD;
               err_d   = 3'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sector reads, header capture, row/column tracking and pixel output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_lba_q <= '0; sec_addr_q <= '0; offset_q <= '0;
         width_q     <= '0; height_q   <= '0; exp_w_q  <= '0;
         exp_h_q     <= '0; bpp_q      <= '0; sig0_q   <= '0;
         sig1_q      <= '0; b_q        <= '0; g_q      <= '0;
         r_q         <= '0; idx_q      <= '0; first_sec_q <= 1'b0;
         rd_q        <= 1'b0; rowbyte_q <= '0; col_q   <= '0;
         row_q       <= '0; pb_q       <= '0; wen_q    <= 1'b0;
         lend_q      <= 1'b0; wdata_q  <= '0;
      end else begin
         if (w_start_ok) begin
            start_lba_q <= start_lba;
            exp_w_q     <= exp_width;
            exp_h_q     <= exp_height;
            sec_addr_q  <= start_lba;
            idx_q       <= 9'd0;
         end
         if (state_q == S_HDR_RD && sd_sec_read_data_valid) begin
            case (idx_q)
               9'd0:  sig0_q         <= sd_sec_read_data;
               9'd1:  sig1_q         <= sd_sec_read_data;
               9'd10: offset_q[7:0]  <= sd_sec_read_data;
               9'd11: offset_q[15:8] <= sd_sec_read_data;
               9'd12: offset_q[23:16]<= sd_sec_read_data;
               9'd13: offset_q[31:24]<= sd_sec_read_data;
               9'd18: width_q[7:0]   <= sd_sec_read_data;
               9'd19: width_q[15:8]  <= sd_sec_read_data;
               9'd20: width_q[23:16] <= sd_sec_read_data;
               9'd21: width_q[31:24] <= sd_sec_read_data;
               9'd22: height_q[7:0]  <= sd_sec_read_data;
               9'd23: height_q[15:8] <= sd_sec_read_data;
               9'd24: height_q[23:16]<= sd_sec_read_data;
               9'd25: height_q[31:24]<= sd_sec_read_data;
               9'd28: bpp_q[7:0]     <= sd_sec_read_data;
               9'd29: bpp_q[15:8]    <= sd_sec_read_data;
               default: ;
            endcase
            idx_q <= idx_q + 9'd1;
         end
         if (state_q == S_DAT_RD && sd_sec_read_data_valid) idx_q <= idx_q + 9'd1;
         if (sd_sec_read_end) begin
            idx_q <= 9'd0;
            if (state_q == S_DAT_RD) first_sec_q <= 1'b0;
         end
         if (state_q == S_HDR_CHK) begin
            sec_addr_q  <= start_lba_q + {9'd0, offset_q[31:9]};
            first_sec_q <= 1'b1;
            rowbyte_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pb_q        <= '0;
         end
         if (state_q == S_NEXT_SEC) sec_addr_q <= sec_addr_q + 32'd1;
         // Request is held until the sector-end pulse, dropping one cycle later
         if (w_launch) rd_q <= 1'b1;
         else if (sd_sec_read_end) rd_q <= 1'b0;
         if (w_take) rowbyte_q <= (rowbyte_q == w_stride - 18'd1) ? 18'd0 : rowbyte_q + 18'd1;
         if (w_pix_byte) begin
            case (pb_q)
               2'd0:    b_q <= sd_sec_read_data;
               2'd1:    g_q <= sd_sec_read_data;
               2'd2:    r_q <= sd_sec_read_data;
               default: ;
            endcase
            pb_q <= w_last_pb ? 2'd0 : pb_q + 2'd1;
         end
         if (w_emit) begin
            col_q   <= w_col_last ? 16'd0 : col_q + 16'd1;
            wdata_q <= w_pix[OUT_W-1:0];
         end
         if (w_row_last) row_q <= w_row_d;
         wen_q  <= w_emit;
         lend_q <= w_emit && w_col_last;
      end
   end

   assign err              = err_q;
   assign write_en         = wen_q;
   assign write_data       = wdata_q;
   assign line_end         = lend_q;
   assign sd_sec_read      = rd_q;
   assign sd_sec_read_addr = sec_addr_q;

endmodule
`default_nettype wire
